// File: rtl/decode_pipe.sv
// decode_pipe: one-entry registered MIPS decode stage with a hazard-wait FSM
// and a write-first register file.
module decode_pipe #(
  parameter int  XLEN     = 32,
  parameter int  NREG     = 32,
  parameter int  JAL_LINK = 31,
  localparam int RAW      = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  input  logic            flush_i,
  input  logic            wb_en_i,
  input  logic [RAW-1:0]  wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  input  logic            branch_resume_i,
  input  logic            dmem_resume_i,
  output logic            reg_write_o,
  output logic            mem_to_reg_o,
  output logic            mem_write_o,
  output logic            branch_o,
  output logic [3:0]      alu_control_o,
  output logic [1:0]      alu_src_o,
  output logic [1:0]      j_inst_o,
  output logic [RAW-1:0]  dst_reg_o,
  output logic [RAW-1:0]  rs_o,
  output logic [RAW-1:0]  rt_o,
  output logic [4:0]      shamt_o,
  output logic [XLEN-1:0] rd1_o,
  output logic [XLEN-1:0] rd2_o,
  output logic [XLEN-1:0] imm_o,
  output logic [XLEN-1:0] pc_plus_4_o,
  output logic [XLEN-1:0] jump_addr_o,
  output logic            illegal_o
);
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

  typedef enum logic [1:0] {RUN, BR_WAIT, MEM_WAIT} state_e;

  typedef struct packed {
    logic            reg_write;
    logic            mem_to_reg;
    logic            mem_write;
    logic            branch;
    logic [3:0]      alu_control;
    logic [1:0]      alu_src;
    logic [1:0]      j_inst;
    logic [RAW-1:0]  dst_reg;
    logic [RAW-1:0]  rs;
    logic [RAW-1:0]  rt;
    logic [4:0]      shamt;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc_plus_4;
    logic [XLEN-1:0] jump_addr;
    logic            illegal;
  } dec_t;

  state_e          state_q, state_d;
  dec_t            dec_q, dec_d;
  logic            out_valid_q, out_valid_d;
  logic [XLEN-1:0] rf_q [NREG];
  logic [5:0]      op, fn;
  logic [RAW-1:0]  rs_a, rt_a, rd_a;
  logic [XLEN-1:0] rd1, rd2;
  logic            xfer, zext;

  assign op   = inst_i[31:26];
  assign fn   = inst_i[5:0];
  assign rs_a = RAW'(inst_i[25:21]);
  assign rt_a = RAW'(inst_i[20:16]);
  assign rd_a = RAW'(inst_i[15:11]);
  assign zext = op inside {OP_ANDI, OP_ORI, OP_XORI};
  assign xfer = in_valid_i && in_ready_o;

  // write-first: a same-cycle writeback is visible to the instruction being accepted
  assign rd1 = rs_a == '0 ? '0 : (wb_en_i && wb_addr_i == rs_a) ? wb_data_i : rf_q[rs_a];
  assign rd2 = rt_a == '0 ? '0 : (wb_en_i && wb_addr_i == rt_a) ? wb_data_i : rf_q[rt_a];

  always_comb begin
    dec_d           = '0;
    dec_d.rs        = rs_a;
    dec_d.rt        = rt_a;
    dec_d.shamt     = inst_i[10:6];
    dec_d.rd1       = rd1;
    dec_d.rd2       = rd2;
    dec_d.imm       = zext ? XLEN'(inst_i[15:0]) : {{(XLEN-16){inst_i[15]}}, inst_i[15:0]};
    dec_d.pc_plus_4 = pc_i + XLEN'(4);
    dec_d.jump_addr = {pc_i[XLEN-1:28], inst_i[25:0], 2'b00};
    case (op)
      OP_R:
        case (fn)
          6'h20, 6'h21: dec_d.reg_write = 1'b1;
          6'h23: {dec_d.reg_write, dec_d.alu_control} = 5'b1_0001;
          6'h24: {dec_d.reg_write, dec_d.alu_control} = 5'b1_0010;
          6'h25: {dec_d.reg_write, dec_d.alu_control} = 5'b1_0011;
          6'h27: {dec_d.reg_write, dec_d.alu_control} = 5'b1_0100;
          6'h26: {dec_d.reg_write, dec_d.alu_control} = 5'b1_0101;
          6'h00: {dec_d.reg_write, dec_d.alu_control, dec_d.alu_src} = {|inst_i[15:11], 6'b0110_01};
          6'h03: {dec_d.reg_write, dec_d.alu_control, dec_d.alu_src} = 7'b1_0111_01;
          6'h02: {dec_d.reg_write, dec_d.alu_control, dec_d.alu_src} = 7'b1_1000_01;
          6'h2A: {dec_d.reg_write, dec_d.alu_control} = 5'b1_1001;
          6'h2B: {dec_d.reg_write, dec_d.alu_control} = 5'b1_1010;
          6'h08: {dec_d.alu_control, dec_d.j_inst} = 6'b1110_11;
          default: dec_d.illegal = 1'b1;
        endcase
      OP_ADDIU: {dec_d.reg_write, dec_d.alu_src} = 3'b1_10;
      OP_ANDI:  {dec_d.reg_write, dec_d.alu_control, dec_d.alu_src} = 7'b1_0010_10;
      OP_ORI:   {dec_d.reg_write, dec_d.alu_control, dec_d.alu_src} = 7'b1_0011_10;
      OP_XORI:  {dec_d.reg_write, dec_d.alu_control, dec_d.alu_src} = 7'b1_0101_10;
      OP_LUI:   {dec_d.reg_write, dec_d.alu_control, dec_d.alu_src} = 7'b1_1011_10;
      OP_LW:    {dec_d.reg_write, dec_d.mem_to_reg, dec_d.alu_src} = 4'b11_10;
      OP_SW:    {dec_d.mem_write, dec_d.alu_src} = 3'b1_11;
      OP_BEQ:   {dec_d.branch, dec_d.alu_control} = 5'b1_0001;
      OP_J:     dec_d.j_inst = 2'b01;
      OP_JAL:   {dec_d.reg_write, dec_d.j_inst} = 3'b1_10;
      default:  dec_d.illegal = 1'b1;
    endcase
    dec_d.dst_reg = (dec_d.illegal || op == OP_J) ? '0 : op == OP_JAL ? RAW'(JAL_LINK) : op == OP_R ? rd_a : rt_a;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    end else if (wb_en_i && wb_addr_i != '0) begin
      rf_q[wb_addr_i] <= wb_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dec_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      if (xfer) dec_q <= dec_d;
    end
  end

  assign out_valid_d = flush_i ? 1'b0 : xfer ? 1'b1 : out_ready_i ? 1'b0 : out_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  // resume pulses only matter in their own wait state, so one seen in RUN is dropped
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      state_d = !xfer ? RUN : (dec_d.branch || dec_d.j_inst != 2'b00) ? BR_WAIT :
                          (dec_d.mem_to_reg || dec_d.mem_write) ? MEM_WAIT : RUN;
      BR_WAIT:  state_d = branch_resume_i ? RUN : BR_WAIT;
      MEM_WAIT: state_d = dmem_resume_i ? RUN : MEM_WAIT;
      default:  state_d = RUN;
    endcase
    if (flush_i) state_d = RUN;
  end

  always_comb begin
    in_ready_o  = state_q == RUN && (!out_valid_q || out_ready_i) && !flush_i;
    out_valid_o = out_valid_q;
  end

  assign {reg_write_o, mem_to_reg_o, mem_write_o, branch_o, alu_control_o, alu_src_o, j_inst_o,
          dst_reg_o, rs_o, rt_o, shamt_o, rd1_o, rd2_o, imm_o, pc_plus_4_o, jump_addr_o,
          illegal_o} = dec_q;
endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: directed stimulus for decode_pipe, checked every cycle against
// a mnemonic-level model plus hand-computed literal expectations.
module tb_decode_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b1, flush = 1'b0;
  logic [31:0] inst = '0, pc = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        branch_resume = 1'b0, dmem_resume = 1'b0;
  logic        in_ready, out_valid, reg_write, mem_to_reg, mem_write, branch, illegal;
  logic [3:0]  alu_control;
  logic [1:0]  alu_src, j_inst;
  logic [4:0]  dst_reg, rs, rt, shamt;
  logic [31:0] rd1, rd2, imm, pc_plus_4, jump_addr;

  always #5 clk = ~clk;

  decode_pipe dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .inst_i(inst), .pc_i(pc), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .flush_i(flush), .wb_en_i(wb_en), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .branch_resume_i(branch_resume), .dmem_resume_i(dmem_resume),
    .reg_write_o(reg_write), .mem_to_reg_o(mem_to_reg), .mem_write_o(mem_write),
    .branch_o(branch), .alu_control_o(alu_control), .alu_src_o(alu_src),
    .j_inst_o(j_inst), .dst_reg_o(dst_reg), .rs_o(rs), .rt_o(rt), .shamt_o(shamt),
    .rd1_o(rd1), .rd2_o(rd2), .imm_o(imm), .pc_plus_4_o(pc_plus_4),
    .jump_addr_o(jump_addr), .illegal_o(illegal)
  );

  typedef enum {M_ADD, M_ADDU, M_SUBU, M_AND, M_OR, M_NOR, M_XOR, M_SLL, M_SRA, M_SRL,
                M_SLT, M_SLTU, M_JR, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_SW,
                M_BEQ, M_J, M_JAL, M_ILL} mn_t;

  typedef struct packed {
    logic rw, m2r, mw, br;
    logic [3:0] ac;
    logic [1:0] src, j;
    logic [4:0] dst, rs, rt, sh;
    logic [31:0] rd1, rd2, imm, pc4, ja;
    logic ill;
  } exp_t;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic mn_t mnem(input logic [31:0] i);
    if (i[31:26] == 6'h00)
      case (i[5:0])
        6'h20: return M_ADD;   6'h21: return M_ADDU; 6'h23: return M_SUBU;
        6'h24: return M_AND;   6'h25: return M_OR;   6'h27: return M_NOR;
        6'h26: return M_XOR;   6'h00: return M_SLL;  6'h03: return M_SRA;
        6'h02: return M_SRL;   6'h2A: return M_SLT;  6'h2B: return M_SLTU;
        6'h08: return M_JR;    default: return M_ILL;
      endcase
    case (i[31:26])
      6'h09: return M_ADDIU; 6'h0C: return M_ANDI; 6'h0D: return M_ORI;
      6'h0E: return M_XORI;  6'h0F: return M_LUI;  6'h23: return M_LW;
      6'h2B: return M_SW;    6'h04: return M_BEQ;  6'h02: return M_J;
      6'h03: return M_JAL;   default: return M_ILL;
    endcase
  endfunction

  function automatic exp_t expect_of(input logic [31:0] i, input logic [31:0] p,
                                     input logic [31:0] a, input logic [31:0] b);
    mn_t m = mnem(i);
    exp_t e = '0;
    e.ill = m == M_ILL;
    e.rw  = (m inside {M_ADD, M_ADDU, M_SUBU, M_AND, M_OR, M_NOR, M_XOR, M_SLL, M_SRA, M_SRL,
                       M_SLT, M_SLTU, M_ADDIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW, M_JAL})
            && !(m == M_SLL && i[15:11] == 5'd0);
    e.m2r = m == M_LW;
    e.mw  = m == M_SW;
    e.br  = m == M_BEQ;
    case (m)
      M_SUBU, M_BEQ: e.ac = 4'd1;
      M_AND, M_ANDI: e.ac = 4'd2;
      M_OR, M_ORI:   e.ac = 4'd3;
      M_NOR:         e.ac = 4'd4;
      M_XOR, M_XORI: e.ac = 4'd5;
      M_SLL:         e.ac = 4'd6;
      M_SRA:         e.ac = 4'd7;
      M_SRL:         e.ac = 4'd8;
      M_SLT:         e.ac = 4'd9;
      M_SLTU:        e.ac = 4'd10;
      M_LUI:         e.ac = 4'd11;
      M_JR:          e.ac = 4'd14;
      default:       e.ac = 4'd0;
    endcase
    e.src = (m inside {M_SLL, M_SRA, M_SRL}) ? 2'd1 : m == M_SW ? 2'd3 :
            (m inside {M_ADDIU, M_ANDI, M_ORI, M_XORI, M_LUI, M_LW}) ? 2'd2 : 2'd0;
    e.j   = m == M_J ? 2'd1 : m == M_JAL ? 2'd2 : m == M_JR ? 2'd3 : 2'd0;
    e.dst = (m == M_ILL || m == M_J) ? 5'd0 : m == M_JAL ? 5'd31 :
            i[31:26] == 6'h00 ? i[15:11] : i[20:16];
    e.rs  = i[25:21];
    e.rt  = i[20:16];
    e.sh  = i[10:6];
    e.rd1 = a;
    e.rd2 = b;
    e.imm = (m inside {M_ANDI, M_ORI, M_XORI}) ? {16'h0, i[15:0]} : {{16{i[15]}}, i[15:0]};
    e.pc4 = p + 32'd4;
    e.ja  = {p[31:28], i[25:0], 2'b00};
    return e;
  endfunction

  // model: architectural register file, expected output record, and which hazard we wait on
  logic [31:0] m_rf [32];
  exp_t        m_e;
  logic        m_ov;
  int          m_wait;
  logic        m_ready;

  assign m_ready = m_wait == 0 && (!m_ov || out_ready) && !flush;

  function automatic logic [31:0] rdv(input logic [4:0] a);
    return a == 5'd0 ? 32'd0 : (wb_en && wb_addr == a) ? wb_data : m_rf[a];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_rf[i] <= '0;
      m_e    <= '0;
      m_ov   <= 1'b0;
      m_wait <= 0;
    end else begin
      if (wb_en && wb_addr != 5'd0) m_rf[wb_addr] <= wb_data;
      if (in_valid && m_ready) m_e <= expect_of(inst, pc, rdv(inst[25:21]), rdv(inst[20:16]));
      m_ov <= flush ? 1'b0 : (in_valid && m_ready) ? 1'b1 : out_ready ? 1'b0 : m_ov;
      if (flush) m_wait <= 0;
      else if (m_wait == 0 && in_valid && m_ready)
        m_wait <= (mnem(inst) inside {M_BEQ, M_J, M_JAL, M_JR}) ? 1 :
                  (mnem(inst) inside {M_LW, M_SW}) ? 2 : 0;
      else if ((m_wait == 1 && branch_resume) || (m_wait == 2 && dmem_resume)) m_wait <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", out_valid, m_ov);
      chk("in_ready", in_ready, m_ready);
      if (m_ov) begin
        chk("reg_write", reg_write, m_e.rw);
        chk("mem_to_reg", mem_to_reg, m_e.m2r);
        chk("mem_write", mem_write, m_e.mw);
        chk("branch", branch, m_e.br);
        chk("alu_control", alu_control, m_e.ac);
        chk("alu_src", alu_src, m_e.src);
        chk("j_inst", j_inst, m_e.j);
        chk("dst_reg", dst_reg, m_e.dst);
        chk("rs", rs, m_e.rs);
        chk("rt", rt, m_e.rt);
        chk("shamt", shamt, m_e.sh);
        chk("rd1", rd1, m_e.rd1);
        chk("rd2", rd2, m_e.rd2);
        chk("imm", imm, m_e.imm);
        chk("pc_plus_4", pc_plus_4, m_e.pc4);
        chk("jump_addr", jump_addr, m_e.ja);
        chk("illegal", illegal, m_e.ill);
      end
    end
  end

  function automatic logic [31:0] r_t(input int s, input int t, input int d, input int sh, input logic [5:0] f);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'(sh), f};
  endfunction

  function automatic logic [31:0] i_t(input logic [5:0] o, input int s, input int t, input logic [15:0] k);
    return {o, 5'(s), 5'(t), k};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] i, input logic [31:0] p);
    inst = i;
    pc = p;
    in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    chk("reset out_valid", out_valid, 0);
    chk("reset reg_write", reg_write, 0);
    chk("reset j_inst", j_inst, 0);
    chk("reset illegal", illegal, 0);
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after reset", in_ready, 1);
    tick;
    wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
    tick;
    wb_addr = 5'd2; wb_data = 32'd7;
    tick;
    wb_en = 1'b0;
    issue(r_t(1, 2, 3, 0, 6'h21), 32'h0040_0000);
    @(negedge clk);
    chk("addu out_valid", out_valid, 1);
    chk("addu rd1", rd1, 5);
    chk("addu rd2", rd2, 7);
    chk("addu alu_control", alu_control, 0);
    chk("addu dst_reg", dst_reg, 3);
    tick;
    issue(i_t(6'h0D, 0, 4, 16'h8000), 32'h0040_0004);
    @(negedge clk);
    chk("ori zext imm", imm, 32'h0000_8000);
    tick;
    issue(i_t(6'h09, 0, 5, 16'h8000), 32'h0040_0008);
    @(negedge clk);
    chk("addiu sext imm", imm, 32'hFFFF_8000);
    tick;
    issue(r_t(0, 2, 9, 3, 6'h03), 32'h0040_000C);
    issue(32'h0000_0000, 32'h0040_000C);
    @(negedge clk);
    chk("nop reg_write", reg_write, 0);
    tick;
    dmem_resume = 1'b1;
    tick;
    dmem_resume = 1'b0;
    issue({6'h03, 26'h000_0100}, 32'h0040_0010);
    @(negedge clk);
    chk("jal j_inst", j_inst, 2);
    chk("jal dst_reg", dst_reg, 31);
    chk("jal pc_plus_4", pc_plus_4, 32'h0040_0014);
    chk("jal reg_write", reg_write, 1);
    chk("jal in_ready", in_ready, 0);
    tick;
    tick;
    @(negedge clk);
    chk("br_wait holds", in_ready, 0);
    tick;
    dmem_resume = 1'b1;
    tick;
    dmem_resume = 1'b0;
    branch_resume = 1'b1;
    tick;
    branch_resume = 1'b0;
    @(negedge clk);
    chk("branch_resume releases", in_ready, 1);
    tick;
    out_ready = 1'b0;
    issue(i_t(6'h23, 1, 6, 16'h0004), 32'h0040_0020);
    inst = r_t(1, 2, 10, 0, 6'h20);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall out_valid", out_valid, 1);
      chk("stall in_ready", in_ready, 0);
      chk("stall mem_to_reg", mem_to_reg, 1);
      chk("stall dst_reg", dst_reg, 6);
      tick;
    end
    flush = 1'b1;
    in_valid = 1'b0;
    tick;
    flush = 1'b0;
    @(negedge clk);
    chk("flush out_valid", out_valid, 0);
    chk("flush in_ready", in_ready, 1);
    tick;
    out_ready = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_DEAD;
    issue(r_t(1, 2, 7, 0, 6'h21), 32'h0040_0024);
    wb_en = 1'b0;
    @(negedge clk);
    chk("bypass rd2", rd2, 32'h0000_DEAD);
    chk("bypass rd1", rd1, 5);
    tick;
    wb_en = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234;
    issue(r_t(0, 2, 8, 0, 6'h21), 32'h0040_0028);
    wb_en = 1'b0;
    @(negedge clk);
    chk("r0 bypass blocked", rd1, 0);
    tick;
    issue(r_t(0, 0, 8, 0, 6'h24), 32'h0040_002C);
    @(negedge clk);
    chk("r0 reads zero", rd1, 0);
    tick;
    issue({6'h3F, 26'h0}, 32'h0040_0030);
    @(negedge clk);
    chk("illegal op flag", illegal, 1);
    chk("illegal reg_write", reg_write, 0);
    chk("illegal mem_write", mem_write, 0);
    chk("illegal branch", branch, 0);
    chk("illegal no stall", in_ready, 1);
    tick;
    issue(r_t(1, 2, 3, 0, 6'h3F), 32'h0040_0034);
    @(negedge clk);
    chk("illegal funct flag", illegal, 1);
    tick;
    issue(i_t(6'h2B, 1, 2, 16'h0008), 32'h0040_0038);
    @(negedge clk);
    chk("sw alu_src", alu_src, 3);
    chk("sw mem_write", mem_write, 1);
    tick;
    dmem_resume = 1'b1;
    tick;
    dmem_resume = 1'b0;
    issue({6'h02, 26'h0AB_CDE}, 32'hA000_0000);
    @(negedge clk);
    chk("j jump_addr", jump_addr, 32'hA02A_F378);
    tick;
    branch_resume = 1'b1;
    tick;
    branch_resume = 1'b0;
    issue(r_t(31, 0, 0, 0, 6'h08), 32'h0040_0040);
    @(negedge clk);
    chk("jr j_inst", j_inst, 3);
    chk("jr alu_control", alu_control, 4'hE);
    tick;
    branch_resume = 1'b1;
    tick;
    branch_resume = 1'b0;
    issue(i_t(6'h04, 1, 2, 16'h0010), 32'h0040_0044);
    @(negedge clk);
    chk("beq stalls", in_ready, 0);
    chk("beq branch", branch, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset out_valid", out_valid, 0);
    chk("async reset branch", branch, 0);
    chk("async reset alu_control", alu_control, 0);
    chk("async reset rd2", rd2, 0);
    tick;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    chk("in_ready after mid-stall reset", in_ready, 1);
    tick;
    issue(r_t(1, 2, 9, 0, 6'h21), 32'h0040_0048);
    @(negedge clk);
    chk("regfile cleared rd1", rd1, 0);
    chk("regfile cleared rd2", rd2, 0);
    tick;
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
